mpp_compact_fifo: RTL

Multi-push, peek-window FIFO with a selective pop and order-preserving compaction. This is the successor to the fixed-width multi-push/peek FIFO in the router path.
- Accepts a variable-length burst of 1..DATA_LENGTH words per cycle.
- Exposes a registered window of the oldest PEEK_WIDTH entries.
- Removes any subset of that window via a hit mask; survivors close ranks toward the head in original order.
- Adds occupancy count output, sticky overflow flag and synchronous clear.

---
 rtl/mpp_compact_fifo.sv | 115 +++++++++++
 1 files changed

// File: rtl/mpp_compact_fifo.sv
// Multi-push FIFO with a registered peek window, masked selective pop and
// order-preserving compaction toward the head (entry 0 is always the oldest).
module mpp_compact_fifo #(
    parameter int DEPTH       = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_LENGTH = 9,
    parameter int PEEK_WIDTH  = 4,
    parameter int LEN_W       = $clog2(DATA_LENGTH + 1),
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_clear,
    input  logic                                   i_write_en,
    input  logic [LEN_W-1:0]                       i_write_len,
    input  logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0] i_data_in,
    input  logic                                   i_pop_en,
    input  logic [PEEK_WIDTH-1:0]                  i_data_hit,
    input  logic                                   i_peek_en,
    output logic [PEEK_WIDTH-1:0][DATA_WIDTH-1:0]  o_peek_data,
    output logic [PEEK_WIDTH-1:0]                  o_valid_data,
    output logic                                   o_peek_valid,
    output logic [CNT_W-1:0]                       o_count,
    output logic                                   o_empty,
    output logic                                   o_full,
    output logic                                   o_overflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem, surv_mem, nxt_mem;
    logic [DEPTH-1:0]                 kill;
    logic [CNT_W-1:0]                 count, pop_cnt, base, len_ext, room, nxt_count, idx, pos;
    logic                             accept, reject;

    // Effective hits are confined to live window entries; survivors are
    // gathered in original order, so removal and compaction are one step.
    always_comb begin
        kill    = '0;
        pop_cnt = '0;
        for (int unsigned k = 0; k < PEEK_WIDTH; k++) begin
            kill[k] = i_pop_en && i_data_hit[k] && (CNT_W'(k) < count);
            pop_cnt = pop_cnt + CNT_W'(kill[k]);
        end
        surv_mem = '0;
        idx      = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (!kill[j]) begin
                surv_mem[idx[IDX_W-1:0]] = mem[j];
                idx = idx + CNT_W'(1);
            end
        end
    end

    // Room is judged on the pre-pop count; the append lands after survivors.
    always_comb begin
        base    = count - pop_cnt;
        len_ext = CNT_W'(i_write_len);
        room    = DEPTH_C - count;
        accept  = i_write_en && (i_write_len != '0)
                  && (i_write_len <= LEN_W'(DATA_LENGTH)) && (len_ext <= room);
        reject  = i_write_en && (i_write_len != '0) && !accept;
        nxt_mem = surv_mem;
        pos     = '0;
        for (int unsigned i = 0; i < DATA_LENGTH; i++) begin
            pos = base + CNT_W'(i);
            if (accept && (CNT_W'(i) < len_ext) && (pos < DEPTH_C)) begin
                nxt_mem[pos[IDX_W-1:0]] = i_data_in[i];
            end
        end
        nxt_count = base + (accept ? len_ext : '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem          <= '0;
            count        <= '0;
            o_peek_data  <= '0;
            o_valid_data <= '0;
            o_peek_valid <= 1'b0;
            o_overflow   <= 1'b0;
            o_empty      <= 1'b1;
            o_full       <= 1'b0;
        end else if (i_clear) begin
            count        <= '0;
            o_peek_data  <= '0;
            o_valid_data <= '0;
            o_peek_valid <= 1'b0;
            o_overflow   <= 1'b0;
            o_empty      <= 1'b1;
            o_full       <= 1'b0;
        end else begin
            mem     <= nxt_mem;
            count   <= nxt_count;
            o_empty <= (nxt_count == '0);
            o_full  <= (nxt_count == DEPTH_C);
            if (reject) begin
                o_overflow <= 1'b1;
            end
            if (i_peek_en) begin
                for (int unsigned k = 0; k < PEEK_WIDTH; k++) begin
                    o_valid_data[k] <= (CNT_W'(k) < nxt_count);
                    o_peek_data[k]  <= (CNT_W'(k) < nxt_count) ? nxt_mem[k] : '0;
                end
                o_peek_valid <= 1'b1;
            end else if (accept || (pop_cnt != '0)) begin
                o_peek_valid <= 1'b0;
            end
        end
    end

    assign o_count = count;

endmodule
